// File: rtl/image_frame_ram_if.sv
// Bus-side bundle for the frame-buffer RAM: write/read strobes, shared
// address, write data, registered read data and the frame-complete flag.
interface image_frame_ram_if #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 17
);
  logic              we_i;
  logic              re_i;
  logic [ADDR_W-1:0] adr_i;
  logic [DATA_W-1:0] dat_i;
  logic [DATA_W-1:0] dat_o;
  logic              fin;

  // Capture/read-path side: drives strobes, address and write data.
  modport master (
    output we_i, re_i, adr_i, dat_i,
    input  dat_o, fin
  );

  // RAM side.
  modport slave (
    input  we_i, re_i, adr_i, dat_i,
    output dat_o, fin
  );
endinterface

// File: rtl/image_frame_ram.sv
// Single-port frame-buffer RAM for one camera image. Pixels are written
// sequentially; the write to the last location sets a sticky frame-complete
// flag that locks out further writes until reset. Reads have one cycle of
// latency, are read-before-write, and return zero outside the frame.
module image_frame_ram #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DEPTH  = 76800
) (
  input logic              clk,
  input logic              rst,
  image_frame_ram_if.slave bus
);

  // DEPTH may equal 2**ADDR_W, so the bound needs one extra bit.
  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_FILL,
    ST_DONE
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] dat_q;
  logic              fin_q;
  state_t            state;
  logic              in_range;
  logic              wr_en;
  logic              rd_en;

  // Address qualification and write/read gating; reset overrides both.
  always_comb begin
    in_range = ({1'b0, bus.adr_i} < DEPTH_W);
    wr_en    = !rst && bus.we_i && (state == ST_FILL) && in_range;
    rd_en    = !rst && bus.re_i;
  end

  // Storage write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[bus.adr_i] <= bus.dat_i;
    end
  end

  // Registered read port; sees the old word on a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      dat_q <= '0;
    end else if (rd_en) begin
      if (in_range) begin
        dat_q <= mem[bus.adr_i];
      end else begin
        dat_q <= '0;
      end
    end
  end

  // Frame state: fill until the last location is written, then hold until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FILL;
      fin_q <= 1'b0;
    end else begin
      case (state)
        ST_FILL: begin
          if (wr_en && (bus.adr_i == LAST_ADR)) begin
            state <= ST_DONE;
            fin_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
          fin_q <= 1'b1;
        end
        default: begin
          state <= ST_FILL;
          fin_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dat_o = dat_q;
  assign bus.fin   = fin_q;

endmodule

// File: tb/tb_image_frame_ram.sv
// Bench for image_frame_ram: directed stimulus pushes expected read data
// into a queue; a monitor pops and compares when read data becomes valid.
module tb_image_frame_ram;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DEPTH  = 76800;

  typedef struct {
    string             name;
    logic [DATA_W-1:0] val;
  } exp_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  exp_t exp_q[$];

  image_frame_ram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  image_frame_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge.
  task automatic cyc(input logic r, input logic w, input logic rd,
                     input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    rst       = r;
    bus.we_i  = w;
    bus.re_i  = rd;
    bus.adr_i = a;
    bus.dat_i = d;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e,
                    input string nm);
    exp_t x;
    x.name = nm;
    x.val  = e;
    exp_q.push_back(x);
    cyc(1'b0, 1'b0, 1'b1, a, '0);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cyc(1'b0, 1'b1, 1'b0, a, d);
  endtask

  task automatic check(input string nm, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%03h expected 0x%03h", nm, act, req);
    end
  endtask

  // Monitor: a read accepted at a rising edge is checked at the next falling edge.
  initial begin
    logic took;
    exp_t x;
    forever begin
      @(posedge clk);
      took = bus.re_i && !rst;
      @(negedge clk);
      if (took) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_read: got 0x%03h with no expected entry", bus.dat_o);
        end else begin
          x = exp_q.pop_front();
          if (bus.dat_o !== x.val) begin
            errors++;
            $display("FAIL %s: got 0x%03h expected 0x%03h", x.name, bus.dat_o, x.val);
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    bus.we_i  = 1'b0;
    bus.re_i  = 1'b0;
    bus.adr_i = '0;
    bus.dat_i = '0;

    // Reset overrides writes and reads; memory survives.
    cyc(1'b1, 1'b0, 1'b0, 17'd0, 12'h000);
    wr(17'd5, 12'h0AB);
    cyc(1'b1, 1'b1, 1'b1, 17'd5, 12'hFFF);
    cyc(1'b1, 1'b1, 1'b1, 17'd5, 12'hFFF);
    cyc(1'b0, 1'b0, 1'b0, 17'd0, 12'h000);
    check("reset_dat_o", bus.dat_o, 12'h000);
    check("reset_fin", {11'd0, bus.fin}, 12'h000);
    rd(17'd5, 12'h0AB, "reset_keeps_mem5");

    // Basic write then read.
    wr(17'd0, 12'hABC);
    wr(17'd1, 12'h123);
    rd(17'd0, 12'hABC, "basic_rd0");
    rd(17'd1, 12'h123, "basic_rd1");
    cyc(1'b0, 1'b0, 1'b0, 17'd0, 12'h000);
    check("basic_fin", {11'd0, bus.fin}, 12'h000);

    // Out-of-range writes ignored, reads return zero.
    wr(17'd76800, 12'h555);
    wr(17'd131071, 12'h555);
    cyc(1'b0, 1'b0, 1'b0, 17'd0, 12'h000);
    check("oor_fin", {11'd0, bus.fin}, 12'h000);
    rd(17'd76800, 12'h000, "oor_rd76800");
    rd(17'd131071, 12'h000, "oor_rd131071");
    rd(17'd0, 12'hABC, "oor_rd0_unchanged");

    // Read-before-write, then hold with re_i low.
    wr(17'd7, 12'h111);
    exp_q.push_back('{name: "rbw_old", val: 12'h111});
    cyc(1'b0, 1'b1, 1'b1, 17'd7, 12'h222);
    rd(17'd7, 12'h222, "rbw_new");
    cyc(1'b0, 1'b0, 1'b0, 17'd3, 12'h000);
    cyc(1'b0, 1'b0, 1'b0, 17'd9, 12'h000);
    check("hold_dat_o", bus.dat_o, 12'h222);

    // Full frame: data = low 12 address bits.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) begin
        @(negedge clk);
        check("fin_before_last", {11'd0, bus.fin}, 12'h000);
        bus.adr_i = ADDR_W'(i);
        bus.dat_i = DATA_W'(i);
        bus.we_i  = 1'b1;
      end else begin
        wr(ADDR_W'(i), DATA_W'(i));
      end
    end
    cyc(1'b0, 1'b0, 1'b0, 17'd0, 12'h000);
    check("fin_after_last", {11'd0, bus.fin}, 12'h001);
    rd(17'd100, 12'h064, "frame_rd100");
    rd(17'd76799, 12'hBFF, "frame_rd76799");

    // Locked frame ignores writes.
    wr(17'd10, 12'hFFF);
    rd(17'd10, 12'h00A, "lockout_rd10");
    cyc(1'b0, 1'b0, 1'b0, 17'd0, 12'h000);
    check("lockout_fin", {11'd0, bus.fin}, 12'h001);

    // Reset releases the lock.
    cyc(1'b1, 1'b0, 1'b0, 17'd0, 12'h000);
    cyc(1'b0, 1'b0, 1'b0, 17'd0, 12'h000);
    check("rst_clears_fin", {11'd0, bus.fin}, 12'h000);
    wr(17'd10, 12'hFFF);
    rd(17'd10, 12'hFFF, "unlock_rd10");
    cyc(1'b0, 1'b0, 1'b0, 17'd0, 12'h000);
    cyc(1'b0, 1'b0, 1'b0, 17'd0, 12'h000);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected reads never observed, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
